adc_conv_scheduler: RTL and testbench
=====================================

# adc_conv_scheduler

Conversion scheduler for the 8-bit serial ADC on the ADC/7-segment board path. It paces conversions from a programmable sample-period timer and sequences the chip-select/serial-clock frame. It deserialises the returned word and hands the 8-bit result to downstream logic (display conversion, DAC loopback) through a valid/ack handshake with overrun reporting. It replaces free-running conversion with scheduled, rate-controlled sampling.

## Interface
- CLK_DIV, 4 — clk cycles per sclk half-period (≥1)
- SAMPLE_PERIOD, 1000 — clk cycles between scheduled conversion starts (≥2)
- FRAME_BITS, 16 — sclk cycles per conversion frame
- LEAD_BITS, 3 — leading bits discarded before the data MSB
- DATA_BITS, 8 — result width
- clk  in  1  system clock
- rst  in  1  reset; asynchronous and active-high
- en  in  1  enables the sample-period timer
- sdata  in  1  ADC serial data
- sclk  out  1  ADC serial clock; idles high
- cs  out  1  ADC chip select, active-low
- sample  out  DATA_BITS  last completed result
- sample_valid  out  1  result pending, held until sample_ack
- sample_ack  in  1  consumer accepts the pending result
- busy  out  1  frame in progress (cs low)
- overrun  out  1  sticky: a result was overwritten while still pending
- missed  out  1  sticky: a timer tick occurred while busy
- clr_flags  in  1  synchronous clear of overrun and missed

## Operation
- Reset values: sclk=1, cs=1, sample=0, sample_valid=0, busy=0, overrun=0, missed=0; FSM=IDLE; all counters 0.
- Period timer: counts 0..SAMPLE_PERIOD-1 while en=1 and wraps. A tick is generated on the wrap to 0. When en=0 the timer is held at 0, so the first tick arrives SAMPLE_PERIOD cycles after en rises.
- FSM states:
  - IDLE: on tick, go to FRAME, cs←0, clear bit counter and divider.
  - FRAME: the divider counts 0..CLK_DIV-1; at terminal count sclk toggles. On each low→high toggle, shreg←{shreg[FRAME_BITS-2:0], sdata} and the bit counter increments. After the FRAME_BITS-th rising toggle, go to DONE.
  - DONE (1 cycle): cs←1, sclk stays 1, sample←shreg[FRAME_BITS-1-LEAD_BITS -: DATA_BITS] (bits 12..5 by default), sample_valid←1, then go to IDLE.
- Tick in FRAME or DONE: the tick is dropped and missed←1. Conversions are never queued.
- Handshake: sample_valid clears on the cycle after sample_ack=1. If DONE coincides with sample_valid=1 and sample_ack=0, sample is overwritten, sample_valid stays 1 and overrun←1. If DONE coincides with sample_ack=1, the new result wins: sample_valid=1 and no overrun.
- Deasserting en mid-frame does not abort the frame; the frame completes normally and no further ticks occur.
- clr_flags has priority over a same-cycle set: flags read 0 after that cycle.
- Asserting rst mid-frame forces cs=1 and sclk=1 immediately and discards the partial word.

## Timing
- Tick at cycle T gives cs=0 at T+1.
- sclk first falls at T+1+CLK_DIV. Rising edge k (k=1..FRAME_BITS) occurs at T+1+2·k·CLK_DIV.
- DONE is the cycle after the last rising edge. cs=1 and sample_valid=1 are visible at T+2+2·FRAME_BITS·CLK_DIV, which is T+130 with defaults.
- busy equals ~cs.
- Minimum conversion-to-conversion spacing is 2·FRAME_BITS·CLK_DIV+2 cycles. A smaller SAMPLE_PERIOD is legal and causes missed.
- sdata is sampled at the clk edge where sclk rises; the ADC must present each bit before that edge.

## Test plan
- Nominal: defaults, en=1, ADC model returns 16'b000_10110101_00000. Expect sample=8'hB5, sample_valid=1 at 130 cycles after the tick, exactly 16 sclk rising edges while cs=0, and sclk=1 whenever cs=1.
- Handshake: pulse sample_ack 1 cycle after valid. Expect sample_valid low the next cycle. The next conversion delivers a new value with overrun=0.
- Overrun: never ack across two conversions returning 8'h11 then 8'h22. Expect sample=8'h22, sample_valid=1, overrun=1. Then clr_flags gives overrun=0.
- Missed tick: SAMPLE_PERIOD=100 (less than 130). Expect missed=1, every frame still exactly 16 sclk edges, and no frame started while busy.
- Reset mid-frame: assert rst after 7 rising edges. Expect cs=1, sclk=1, sample_valid=0 immediately. After release with en=1, the first tick arrives SAMPLE_PERIOD cycles later and yields a clean frame.
- Enable drop: en 1→0 mid-frame. Expect the frame to complete with a valid sample, then no further cs assertion for ≥3·SAMPLE_PERIOD cycles.

Source files
------------

// File: rtl/adc_conv_scheduler.sv
// Paced conversion scheduler for an 8-bit serial ADC: period timer, cs/sclk frame
// sequencer, deserialiser and a valid/ack result port with sticky overrun/missed flags.
module adc_conv_scheduler #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int FRAME_BITS    = 16,
  parameter int LEAD_BITS     = 3,
  parameter int DATA_BITS     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sdata,
  output logic                 sclk,
  output logic                 cs,
  output logic [DATA_BITS-1:0] sample,
  output logic                 sample_valid,
  input  logic                 sample_ack,
  output logic                 busy,
  output logic                 overrun,
  output logic                 missed,
  input  logic                 clr_flags,
  output logic [1:0]           dbg_state
);

  localparam int TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  sample_q, sample_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;
  logic                  missed_q, missed_d;
  logic                  tick;

  // Result port: sample_valid rises with a new result and holds until the cycle
  // after sample_ack=1; a new result always wins over a same-cycle ack.
  always_comb begin
    tick      = en && (tmr_q == TMR_LAST);
    tmr_d     = (!en || tick) ? '0 : tmr_q + TMR_W'(1);
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    sample_d  = sample_q;
    sclk_d    = sclk_q;
    cs_d      = cs_q;
    valid_d   = sample_ack ? 1'b0 : valid_q;
    overrun_d = overrun_q;
    missed_d  = missed_q;

    if (tick && state_q != S_IDLE) missed_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d = S_FRAME;
          cs_d    = 1'b0;
          sclk_d  = 1'b1;
          div_d   = '0;
          bit_d   = '0;
        end
      end
      S_FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Capture on the low-to-high sclk toggle; first bit lands in the MSB.
          if (!sclk_q) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], sdata};
            bit_d   = bit_q + BIT_W'(1);
            if (bit_q == BIT_LAST) state_d = S_DONE;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      S_DONE: begin
        cs_d     = 1'b1;
        sclk_d   = 1'b1;
        sample_d = shreg_q[FRAME_BITS-1-LEAD_BITS -: DATA_BITS];
        valid_d  = 1'b1;
        if (valid_q && !sample_ack) overrun_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (clr_flags) begin
      overrun_d = 1'b0;
      missed_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      div_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      sample_q  <= '0;
      sclk_q    <= 1'b1;
      cs_q      <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      sample_q  <= sample_d;
      sclk_q    <= sclk_d;
      cs_q      <= cs_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      missed_q  <= missed_d;
    end
  end

  assign sclk         = sclk_q;
  assign cs           = cs_q;
  assign busy         = ~cs_q;
  assign sample       = sample_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign missed       = missed_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Bench for adc_conv_scheduler: a default-rate instance for the scenario walk and a
// fast-rate instance whose sample period is shorter than one frame.
module tb_adc_conv_scheduler;

  localparam int CLK_DIV    = 4;
  localparam int FRAME_BITS = 16;
  localparam int SP         = 1000;
  localparam int SP_F       = 100;
  localparam int FRAME_LOW  = 2 * FRAME_BITS * CLK_DIV + 1;
  localparam int OCCUPY     = FRAME_LOW + 1;
  localparam int SPACING_F  = SP_F * ((OCCUPY + SP_F - 1) / SP_F);
  localparam int RUN_F      = 1050;

  logic       clk = 1'b0;
  logic       rst, en, sdata, sample_ack, clr_flags;
  logic       sclk, cs, sample_valid, busy, overrun, missed;
  logic [7:0] sample;
  logic [1:0] dbg_state;

  logic       rst_f, en_f, sdata_f, ack_f, clr_f;
  logic       sclk_f, cs_f, valid_f, busy_f, overrun_f, missed_f;
  logic [7:0] sample_f;
  logic [1:0] dbg_f;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  exp_q[$];
  logic [7:0]  exp_f_q[$];
  logic [15:0] word_q[$];

  int m_fall_cnt = 0, m_fall_cyc = 0, m_done_cnt = 0, m_rises = 0;
  int idle_viol = 0, busy_viol = 0;
  int f_fall_cnt = 0, f_last_fall = 0, en_f_cyc = 0;

  adc_conv_scheduler u_dut (
    .clk(clk), .rst(rst), .en(en), .sdata(sdata), .sclk(sclk), .cs(cs),
    .sample(sample), .sample_valid(sample_valid), .sample_ack(sample_ack),
    .busy(busy), .overrun(overrun), .missed(missed), .clr_flags(clr_flags),
    .dbg_state(dbg_state)
  );

  adc_conv_scheduler #(.SAMPLE_PERIOD(SP_F)) u_fast (
    .clk(clk), .rst(rst_f), .en(en_f), .sdata(sdata_f), .sclk(sclk_f), .cs(cs_f),
    .sample(sample_f), .sample_valid(valid_f), .sample_ack(ack_f),
    .busy(busy_f), .overrun(overrun_f), .missed(missed_f), .clr_flags(clr_f),
    .dbg_state(dbg_f)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // ADC models: present each frame bit MSB-first on sclk falling edges
  initial begin
    logic [15:0] w;
    sdata = 1'b0;
    forever begin
      @(negedge cs);
      w = (word_q.size() != 0) ? word_q.pop_front() : 16'($urandom);
      exp_q.push_back(w[12:5]);
      for (int i = 15; i >= 0; i--) begin
        @(negedge sclk or posedge cs);
        if (cs) break;
        sdata = w[i];
      end
    end
  end

  initial begin
    logic [15:0] w;
    sdata_f = 1'b0;
    forever begin
      @(negedge cs_f);
      w = 16'($urandom);
      exp_f_q.push_back(w[12:5]);
      for (int i = 15; i >= 0; i--) begin
        @(negedge sclk_f or posedge cs_f);
        if (cs_f) break;
        sdata_f = w[i];
      end
    end
  end

  // scoreboard: per-frame checks on the default instance
  initial begin
    logic       prev_cs, prev_sclk, in_frame;
    logic [7:0] want;
    prev_cs = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (in_frame && exp_q.size() != 0) void'(exp_q.pop_front());
        in_frame = 1'b0;
      end else begin
        if (prev_cs && !cs) begin
          in_frame = 1'b1; m_rises = 0; m_fall_cyc = cyc; m_fall_cnt++;
        end else if (in_frame && !cs && !prev_sclk && sclk) begin
          m_rises++;
        end
        if (in_frame && !prev_cs && cs) begin
          in_frame = 1'b0;
          m_done_cnt++;
          want = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
          chk("frame_rises", m_rises, FRAME_BITS);
          chk("frame_len", cyc - m_fall_cyc, FRAME_LOW);
          chk("frame_valid", sample_valid, 1'b1);
          chk("frame_sample", sample, want);
        end
        if (cs && !sclk) idle_viol++;
        if (busy !== ~cs) busy_viol++;
      end
      prev_cs = cs; prev_sclk = sclk;
    end
  end

  // scoreboard: fast instance, spacing derived from the next tick after the frame frees up
  initial begin
    logic prev_cs, prev_sclk, in_frame;
    int   rises;
    logic [7:0] want;
    prev_cs = 1'b1; prev_sclk = 1'b1; in_frame = 1'b0; rises = 0;
    forever begin
      @(negedge clk);
      if (!rst_f) begin
        if (prev_cs && !cs_f) begin
          in_frame = 1'b1; rises = 0; f_fall_cnt++;
          if (f_fall_cnt == 1) chk("f_first_fall", cyc - en_f_cyc, SP_F);
          else chk("f_spacing", cyc - f_last_fall, SPACING_F);
          f_last_fall = cyc;
        end else if (in_frame && !cs_f && !prev_sclk && sclk_f) begin
          rises++;
        end
        if (in_frame && !prev_cs && cs_f) begin
          in_frame = 1'b0;
          want = (exp_f_q.size() != 0) ? exp_f_q.pop_front() : 8'hxx;
          chk("f_rises", rises, FRAME_BITS);
          chk("f_sample", sample_f, want);
        end
      end
      prev_cs = cs_f; prev_sclk = sclk_f;
    end
  end

  // driver tasks
  task automatic wait_fall(input int budget);
    int n0 = m_fall_cnt;
    int k = 0;
    while (m_fall_cnt == n0 && k < budget) begin @(negedge clk); #1; k++; end
    chk("wait_cs_fall", m_fall_cnt != n0, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n0 = m_done_cnt;
    int k = 0;
    while (m_done_cnt == n0 && k < budget) begin @(negedge clk); #1; k++; end
    chk("wait_done", m_done_cnt != n0, 1'b1);
  endtask

  task automatic to_cycle(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulse_ack();
    sample_ack = 1'b1;
    @(negedge clk);
    sample_ack = 1'b0;
    #1;
  endtask

  initial begin
    int c0, n0;
    rst = 1'b1; rst_f = 1'b1; en = 1'b0; en_f = 1'b0;
    sample_ack = 1'b0; clr_flags = 1'b0; ack_f = 1'b0; clr_f = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk, 1'b1);
    chk("rst_cs", cs, 1'b1);
    chk("rst_sample", sample, 8'h00);
    chk("rst_valid", sample_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_missed", missed, 1'b0);
    #1; rst = 1'b0; rst_f = 1'b0;

    // fast instance: period shorter than a frame
    @(negedge clk); #1;
    en_f_cyc = cyc; en_f = 1'b1;
    repeat (RUN_F) @(negedge clk);
    #1; en_f = 1'b0;
    repeat (OCCUPY + 20) @(negedge clk);
    #1;
    chk("f_missed", missed_f, 1'b1);
    chk("f_frames", f_fall_cnt, (RUN_F - SP_F + SPACING_F - 1) / SPACING_F);
    chk("f_idle_cs", cs_f, 1'b1);

    // nominal conversion
    word_q.push_back(16'b000_10110101_00000);
    c0 = cyc; en = 1'b1;
    wait_fall(SP + 10);
    chk("first_fall", m_fall_cyc - c0, SP);
    wait_done(FRAME_LOW + 10);
    chk("nominal_sample", sample, 8'hB5);
    chk("nominal_overrun", overrun, 1'b0);

    // handshake: ack one cycle after valid
    @(negedge clk); #1;
    pulse_ack();
    chk("ack_clears", sample_valid, 1'b0);
    wait_done(SP + 10);
    chk("hs_valid", sample_valid, 1'b1);
    chk("hs_overrun", overrun, 1'b0);

    // ack landing on the DONE cycle: new result wins, no overrun
    wait_fall(SP + 10);
    to_cycle(m_fall_cyc + FRAME_LOW - 1);
    pulse_ack();
    chk("ack_at_done_valid", sample_valid, 1'b1);
    chk("ack_at_done_overrun", overrun, 1'b0);
    pulse_ack();

    // overrun: two results without an ack
    word_q.push_back({3'($urandom), 8'h11, 5'($urandom)});
    word_q.push_back({3'($urandom), 8'h22, 5'($urandom)});
    wait_done(SP + FRAME_LOW + 10);
    chk("ovr_first_sample", sample, 8'h11);
    chk("ovr_first_flag", overrun, 1'b0);
    wait_done(SP + 10);
    chk("ovr_sample", sample, 8'h22);
    chk("ovr_valid", sample_valid, 1'b1);
    chk("ovr_flag", overrun, 1'b1);
    chk("ovr_missed", missed, 1'b0);
    clr_flags = 1'b1;
    @(negedge clk); #1;
    clr_flags = 1'b0;
    chk("clr_overrun", overrun, 1'b0);
    chk("clr_keeps_valid", sample_valid, 1'b1);

    // clear on the same cycle an overrun would be set
    wait_fall(SP + 10);
    to_cycle(m_fall_cyc + FRAME_LOW - 1);
    clr_flags = 1'b1;
    @(negedge clk); #1;
    clr_flags = 1'b0;
    chk("clr_priority", overrun, 1'b0);
    chk("clr_priority_valid", sample_valid, 1'b1);
    pulse_ack();

    // enable drop mid-frame
    wait_fall(SP + 10);
    repeat (40) @(negedge clk);
    #1; en = 1'b0;
    wait_done(FRAME_LOW + 10);
    chk("endrop_valid", sample_valid, 1'b1);
    n0 = m_fall_cnt;
    repeat (3 * SP + 10) @(negedge clk);
    #1;
    chk("endrop_no_restart", m_fall_cnt - n0, 0);

    // reset after 7 rising sclk edges
    en = 1'b1;
    wait_fall(SP + 10);
    c0 = 0;
    while (m_rises < 7 && c0 < 200) begin @(negedge clk); #1; c0++; end
    chk("rst_mid_reached", m_rises, 7);
    #2; rst = 1'b1;
    #1;
    chk("rstmid_cs", cs, 1'b1);
    chk("rstmid_sclk", sclk, 1'b1);
    chk("rstmid_valid", sample_valid, 1'b0);
    chk("rstmid_overrun", overrun, 1'b0);
    repeat (3) @(negedge clk);
    #1; c0 = cyc; rst = 1'b0;
    wait_fall(SP + 10);
    chk("rstmid_first_fall", m_fall_cyc - c0, SP);
    wait_done(FRAME_LOW + 10);
    chk("rstmid_missed", missed, 1'b0);

    chk("sclk_idle_high", idle_viol, 0);
    chk("busy_is_not_cs", busy_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
